// File: rtl/operand_bank.sv
// Four operand registers feeding the 4:1 operand mux, plus a start-triggered sequencer that scans sel 0..3.
// Optional macro OPB_WRLOCK_EN: rejects register writes during a scan and pulses wr_err instead.
module operand_bank #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic [1:0]       sel,
    output logic             sel_valid,
    output logic [WIDTH-1:0] inp1,
    output logic [WIDTH-1:0] inp2,
    output logic [WIDTH-1:0] inp3,
    output logic [WIDTH-1:0] inp4,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       sel_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] regs [4];
    logic             write_ok;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                sel_nxt = 2'd0;
                cnt_nxt = 8'd0;
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt = 8'd0;
                    // sel never wraps inside SCAN; the last slot exits to DONE
                    if (sel == 2'd3) begin
                        state_nxt = DONE;
                        sel_nxt   = 2'd0;
                    end else begin
                        sel_nxt = sel + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            sel_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt == SCAN);
            sel_valid <= (state_nxt == SCAN);
            done      <= (state_nxt == DONE);
        end
    end

`ifdef OPB_WRLOCK_EN
    assign write_ok = wr_en && (state != SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (state == SCAN);
        end
    end
`else
    assign write_ok = wr_en;
    assign wr_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign inp1 = regs[0];
    assign inp2 = regs[1];
    assign inp3 = regs[2];
    assign inp4 = regs[3];

endmodule

// File: tb/tb_operand_bank.sv
// Self-checking bench for operand_bank: directed scenarios plus random traffic against a
// timeline model (scan position derived from the edge count since the accepted start).
module tb_operand_bank;

    localparam int WIDTH = 8;
    localparam int H     = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_addr = 2'd0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic [1:0]       sel;
    logic             sel_valid;
    logic [WIDTH-1:0] inp1, inp2, inp3, inp4;
    logic             busy, done, wr_err;

    operand_bank #(.WIDTH(WIDTH), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .sel(sel), .sel_valid(sel_valid),
        .inp1(inp1), .inp2(inp2), .inp3(inp3), .inp4(inp4),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: edge counter, edge index of the accepted start, register contents.
    int               edge_n   = 0;
    int               t0       = 0;
    bit               has_scan = 1'b0;
    bit               exp_err  = 1'b0;
    logic [WIDTH-1:0] mreg [4];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic checkAll();
        int k;
        bit exp_busy;
        k        = edge_n - t0;
        exp_busy = has_scan && (k < 4*H);
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("sel_valid", 32'(sel_valid), 32'(exp_busy));
        checkOutput("sel", 32'(sel), exp_busy ? 32'(k / H) : 32'd0);
        checkOutput("done", 32'(done), 32'(has_scan && (k == 4*H)));
        checkOutput("wr_err", 32'(wr_err), 32'(exp_err));
        checkOutput("inp1", 32'(inp1), 32'(mreg[0]));
        checkOutput("inp2", 32'(inp2), 32'(mreg[1]));
        checkOutput("inp3", 32'(inp3), 32'(mreg[2]));
        checkOutput("inp4", 32'(inp4), 32'(mreg[3]));
    endtask

    task automatic modelEdge();
        int  kp;
        bit  idle_before;
        bit  busy_before;
        kp          = edge_n - t0;
        idle_before = !has_scan || (kp > 4*H);
        busy_before = has_scan && (kp < 4*H);
        edge_n++;
        exp_err = 1'b0;
        if (wr_en) begin
`ifdef OPB_WRLOCK_EN
            if (busy_before) exp_err = 1'b1;
            else             mreg[wr_addr] = wr_data;
`else
            mreg[wr_addr] = wr_data;
`endif
        end
        if (start && idle_before) begin
            has_scan = 1'b1;
            t0       = edge_n;
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [1:0] a, input logic [WIDTH-1:0] d, input bit st);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        start   = st;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset();
        wr_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        has_scan = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        checkAll();
        @(negedge clk);
        @(negedge clk);
        checkAll();
        rst_n = 1'b1;
    endtask

    initial begin
        int done_seen;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        #1;
        doReset();

        // Register load
        applyStimulus(1'b1, 2'd0, 8'hDF, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'hAC, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'h3C, 1'b0);
        applyStimulus(1'b1, 2'd3, 8'h9B, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);

        // Full scan with start retried in SCAN cycle 6 and in DONE
        done_seen = 0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 4*H + 3; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, (i == 6) || (i == 4*H + 1));
            if (done) done_seen++;
        end
        checkOutput("done_count", 32'(done_seen), 32'd1);

        // Start with a simultaneous write, then a write to addr2 while sel=1
        applyStimulus(1'b1, 2'd0, 8'h55, 1'b1);
        checkOutput("inp1_at_sel0", 32'(inp1), 32'h55);
        for (int i = 1; i <= 4*H + 2; i++) begin
            applyStimulus(i == H + 1, 2'd2, 8'hE1, 1'b0);
        end

        // Reset in the middle of a scan, then a clean scan
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 2*H; i++) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("sel_before_abort", 32'(sel), 32'd2);
        doReset();
        done_seen = 0;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 4*H + 2; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0);
            if (done) done_seen++;
        end
        checkOutput("done_after_reset", 32'(done_seen), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                          WIDTH'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
